// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle between a controlling FSM
// and the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per
// clock through a single full-adder cell (a + ~b + carry) with a carry flop.
//
// state | meaning
// IDLE  | waiting for start; results from the last operation held
// RUN   | one bit processed per clock, WIDTH clocks total
// DONE  | one-cycle done pulse; start here is accepted back-to-back
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             msb_a;
  logic             msb_b;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             overflow_q;

  logic             sum_bit;
  logic             carry_nx;
  logic             nb;
  logic [WIDTH-1:0] res_shift;

  // Full-adder cell on the current LSBs, with b inverted for subtraction.
  always_comb begin
    nb        = ~sb[0];
    sum_bit   = sa[0] ^ nb ^ carry;
    carry_nx  = (sa[0] & nb) | (sa[0] & carry) | (nb & carry);
    res_shift = {sum_bit, res};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      msb_a      <= 1'b0;
      msb_b      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sa     <= bus.a;
            sb     <= bus.b;
            carry  <= 1'b1;
            cnt    <= '0;
            msb_a  <= bus.a[WIDTH-1];
            msb_b  <= bus.b[WIDTH-1];
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end

        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= carry_nx;
          res   <= res_shift[WIDTH-1:1];
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            // Last bit: publish results together with the done pulse.
            state      <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            diff_q     <= res_shift;
            borrow_q   <= ~carry_nx;
            overflow_q <= (msb_a != msb_b) && (sum_bit != msb_a);
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: hand-computed vectors, handshake
// timing, ignored mid-run start, back-to-back start and async abort.
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_diff"}, {24'd0, bus.diff}, 32'd0);
    check({tag, "_borrow"}, {31'd0, bus.borrow_out}, 32'd0);
    check({tag, "_ovf"}, {31'd0, bus.overflow}, 32'd0);
  endtask

  // Full operation: start, scramble inputs after accept, time the done pulse.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb, input logic eo);
    int n;
    logic ok;
    logic [7:0] d0;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a = ~a;
    bus.b = ~b;
    check({tag, "_acc_busy"}, {31'd0, bus.busy}, 32'd1);
    check({tag, "_acc_done"}, {31'd0, bus.done}, 32'd0);
    d0 = bus.diff;
    ok = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (bus.busy && bus.done) ok = 1'b0;
      if (!bus.done && bus.diff != d0) ok = 1'b0;
    end while (!bus.done && n < 30);
    check({tag, "_latency"}, n, WIDTH);
    check({tag, "_hold"}, {31'd0, ok}, 32'd1);
    check({tag, "_diff"}, {24'd0, bus.diff}, {24'd0, ed});
    check({tag, "_borrow"}, {31'd0, bus.borrow_out}, {31'd0, eb});
    check({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, eo});
    tick();
    check({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int n;
    int dones;
    logic [7:0] dsave;

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #12;
    check_zero("reset");
    rst_n = 1'b1;
    tick();
    tick();
    check_zero("post_reset");

    run_op("t1", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op("t2a", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op("t2b", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("t3a", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("t3b", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    // Mid-run start must be ignored.
    bus.a = 8'h10;
    bus.b = 8'h01;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    bus.a = 8'hFF;
    bus.b = 8'h00;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    dones = 0;
    dsave = 8'h00;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.done) begin
        dones++;
        dsave = bus.diff;
      end
    end
    check("t4_dones", dones, 1);
    check("t4_diff", {24'd0, dsave}, 32'h0F);
    check("t4_busy", {31'd0, bus.busy}, 32'd0);

    // Start held high across RUN and DONE: re-accepted on the DONE edge.
    bus.a = 8'h05;
    bus.b = 8'h03;
    bus.start = 1'b1;
    tick();
    bus.a = 8'h20;
    bus.b = 8'h30;
    n = 0;
    while (!bus.done && n < 30) begin
      tick();
      n++;
    end
    check("t5_first_lat", n, WIDTH);
    check("t5_first_diff", {24'd0, bus.diff}, 32'h02);
    tick();
    bus.start = 1'b0;
    check("t5_b2b_busy", {31'd0, bus.busy}, 32'd1);
    check("t5_b2b_done", {31'd0, bus.done}, 32'd0);
    n = 1;
    while (!bus.done && n < 30) begin
      tick();
      n++;
    end
    check("t5_gap", n, WIDTH + 1);
    check("t5_diff", {24'd0, bus.diff}, 32'hF0);
    check("t5_borrow", {31'd0, bus.borrow_out}, 32'd1);
    check("t5_ovf", {31'd0, bus.overflow}, 32'd0);
    tick();

    // Abort with async reset mid-run.
    run_op("t6a", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    bus.a = 8'h55;
    bus.b = 8'h11;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t6_held", {24'd0, bus.diff}, 32'h02);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t6_abort");
    tick();
    tick();
    #3;
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) dones++;
    end
    check("t6_no_done", dones, 0);
    check_zero("t6_after");
    run_op("t6b", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
